// File: rtl/nn_train_sequencer.sv
// -----------------------------------------------------------------------------
// nn_train_sequencer
//
// Top-level training scheduler for the backprop neural-network datapath.
// A run covers N_EPOCH epochs. Each epoch covers N_SAMPLES samples. Each
// sample follows the sequence LOAD (1 cycle) -> RUN (N_CYC cycles) ->
// NEXT (1 cycle). The coefficient-renewal strobe fires in NEXT. This block
// replaces the old free-running renewal selector.
//
// Optional feature macro: NN_TRAIN_EARLY_STOP_EN
//   When defined, the input err_below_i and the output converged_o exist.
//   A run ends early after an epoch whose last sample sees err_below_i=1.
//
// Ports
//   clk_i            in   1        system clock, rising edge
//   reset_i          in   1        asynchronous, active-high, clears all state
//   start_i          in   1        begin a run (accepted only in IDLE)
//   abort_i          in   1        stop the run, go to IDLE next cycle
//   train_mode_i     in   1        1 = train, 0 = inference; latched on start
//   err_below_i      in   1        (early-stop build) error under threshold
//   converged_o      out  1        (early-stop build) run ended by err_below_i
//   sample_addr_o    out  ADDR_W   index of the sample being processed
//   sample_valid_o   out  1        1 cycle in LOAD
//   update_coeff_o   out  1        high throughout RUN in train mode
//   enable_update_o  out  1        1-cycle renewal strobe in NEXT, train mode
//   epoch_cnt_o      out  EPOCH_W  completed epochs
//   busy_o           out  1        high in LOAD, RUN, NEXT
//   done_o           out  1        high for exactly 1 cycle (DONE)
//   state_o          out  3        current FSM state, for debug and checkers
//
// Handshake: start_i is a level. It is sampled on each rising edge while the
// FSM is in IDLE and is ignored in every other state. abort_i wins over
// start_i and over every other transition.
// -----------------------------------------------------------------------------
module nn_train_sequencer #(
    parameter int N_CYC     = 13,
    parameter int N_SAMPLES = 4,
    parameter int ADDR_W    = 2,
    parameter int N_EPOCH   = 2,
    parameter int EPOCH_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               train_mode_i,
`ifdef NN_TRAIN_EARLY_STOP_EN
    input  logic               err_below_i,
    output logic               converged_o,
`endif
    output logic [ADDR_W-1:0]  sample_addr_o,
    output logic               sample_valid_o,
    output logic               update_coeff_o,
    output logic               enable_update_o,
    output logic [EPOCH_W-1:0] epoch_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0]         CYC_LAST  = 8'(N_CYC - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_END = EPOCH_W'(N_EPOCH);

    state_t             state_q;
    logic [7:0]         cyc_cnt_q;
    logic [ADDR_W-1:0]  sample_addr_q;
    logic [EPOCH_W-1:0] epoch_cnt_q;
    logic [EPOCH_W-1:0] epoch_cnt_d;
    logic               train_q;
`ifdef NN_TRAIN_EARLY_STOP_EN
    logic               converged_q;
`endif

    // Value the epoch counter takes when the last sample of an epoch retires.
    assign epoch_cnt_d = epoch_cnt_q + EPOCH_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            cyc_cnt_q     <= '0;
            sample_addr_q <= '0;
            epoch_cnt_q   <= '0;
            train_q       <= 1'b0;
`ifdef NN_TRAIN_EARLY_STOP_EN
            converged_q   <= 1'b0;
`endif
        end else if (abort_i) begin
            // epoch_cnt_q holds on purpose. Going to IDLE zeroes every decode.
            state_q       <= S_IDLE;
            cyc_cnt_q     <= '0;
            sample_addr_q <= '0;
            train_q       <= 1'b0;
`ifdef NN_TRAIN_EARLY_STOP_EN
            converged_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q       <= S_LOAD;
                        sample_addr_q <= '0;
                        epoch_cnt_q   <= '0;
                        train_q       <= train_mode_i;
`ifdef NN_TRAIN_EARLY_STOP_EN
                        converged_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    state_q   <= S_RUN;
                    cyc_cnt_q <= '0;
                end
                S_RUN: begin
                    if (cyc_cnt_q == CYC_LAST) begin
                        state_q   <= S_NEXT;
                        cyc_cnt_q <= '0;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (sample_addr_q != ADDR_LAST) begin
                        sample_addr_q <= sample_addr_q + ADDR_W'(1);
                        state_q       <= S_LOAD;
                    end else begin
                        sample_addr_q <= '0;
                        epoch_cnt_q   <= epoch_cnt_d;
`ifdef NN_TRAIN_EARLY_STOP_EN
                        if (err_below_i) begin
                            converged_q <= 1'b1;
                        end
                        if (err_below_i || epoch_cnt_d == EPOCH_END) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
`else
                        if (epoch_cnt_d == EPOCH_END) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
`endif
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decodes of the registered state.
    assign sample_addr_o   = sample_addr_q;
    assign sample_valid_o  = (state_q == S_LOAD);
    assign update_coeff_o  = (state_q == S_RUN) && train_q;
    assign enable_update_o = (state_q == S_NEXT) && train_q;
    assign epoch_cnt_o     = epoch_cnt_q;
    assign busy_o          = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_NEXT);
    assign done_o          = (state_q == S_DONE);
    assign state_o         = state_q;
`ifdef NN_TRAIN_EARLY_STOP_EN
    assign converged_o     = converged_q;
`endif

endmodule
